// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encoding and
//   the default operand width.
//   The unused encoding 2'd3 is not a member of state_e. The FSM treats it as
//   an illegal state and recovers to ST_IDLE through its case default.
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//   Request/result bundle between the switch/button front end (master) and
//   the serial subtractor (slave).
//   start       master->slave  request pulse/level, sampled only when idle
//   a, b        master->slave  minuend / subtrahend, captured on accept
//   busy        slave->master  bits being processed
//   done        slave->master  one-cycle pulse, diff/borrow_out just updated
//   diff        slave->master  a - b modulo 2^WIDTH, held until next result
//   borrow_out  slave->master  1 when a < b (unsigned), held with diff
// -----------------------------------------------------------------------------
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_subtractor_half_sub.sv
// -----------------------------------------------------------------------------
// half_sub
//   Gate-level half subtractor. Two of these plus an OR gate make one full
//   subtractor bit slice.
//   a   in   minuend bit
//   b   in   subtrahend bit
//   d   out  difference bit, a ^ b
//   bo  out  borrow out, ~a & b
// -----------------------------------------------------------------------------
module half_sub (
  input  wire a,
  input  wire b,
  output wire d,
  output wire bo
);

  wire a_n_s;

  xor g_diff   (d, a, b);
  not g_inv    (a_n_s, a);
  and g_borrow (bo, a_n_s, b);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor. It computes diff = a - b, LSB first, one
//   bit per clock. One full-subtractor slice and a borrow flip-flop do the work.
//   It sits between the Nexys A7 switch/button front end and the display logic.
//   clk    in     system clock, rising edge
//   rst_n  in     asynchronous active-low reset
//   bus    slave  start/a/b request, busy/done/diff/borrow_out result
//   Timing: start is accepted at edge t0. busy is high for cycles t0+1 ..
//   t0+WIDTH. done is high for the one cycle after edge t0+WIDTH.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_r;
  state_e             state_nx_s;

  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   d_sh_r;
  logic               borrow_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_out_r;

  logic               busy_nx_s;
  logic               done_nx_s;
  logic               load_s;
  logic               shift_s;
  logic               finish_s;
  logic               last_bit_s;

  // Full-subtractor slice: the first half_sub takes a - b, the second takes
  // the borrow from that partial difference.
  logic               hs1_d_s;
  logic               hs1_bo_s;
  logic               d_bit_s;
  logic               hs2_bo_s;
  logic               borrow_nx_s;
  logic [WIDTH-1:0]   d_sh_nx_s;

  half_sub u_hs_ab (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .d  (hs1_d_s),
    .bo (hs1_bo_s)
  );

  half_sub u_hs_borrow (
    .a  (hs1_d_s),
    .b  (borrow_r),
    .d  (d_bit_s),
    .bo (hs2_bo_s)
  );

  assign borrow_nx_s = hs1_bo_s | hs2_bo_s;
  assign d_sh_nx_s   = {d_bit_s, d_sh_r[WIDTH-1:1]};
  assign last_bit_s  = (cnt_r == CNT_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; the illegal encoding falls back to idle
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx_s = ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output decode; busy/done are decoded from the next state so that
  // their registered copies line up with the state register
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    case (state_r)
      ST_IDLE:  load_s  = bus.start;
      ST_SHIFT: shift_s = 1'b1;
      ST_DONE:  load_s  = 1'b0;
      default:  load_s  = 1'b0;
    endcase
    case (state_nx_s)
      ST_SHIFT: busy_nx_s = 1'b1;
      ST_DONE:  done_nx_s = 1'b1;
      default:  busy_nx_s = 1'b0;
    endcase
    finish_s = shift_s & last_bit_s;
  end

  // Operand capture, serial shift datapath and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      d_sh_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (load_s) begin
      a_sh_r   <= bus.a;
      b_sh_r   <= bus.b;
      borrow_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (shift_s) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      d_sh_r   <= d_sh_nx_s;
      borrow_r <= borrow_nx_s;
      cnt_r    <= cnt_r + CNT_ONE;
    end
  end

  // Registered outputs; diff/borrow_out update only on the edge into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      diff_r       <= {WIDTH{1'b0}};
      borrow_out_r <= 1'b0;
    end else begin
      busy_r <= busy_nx_s;
      done_r <= done_nx_s;
      if (finish_s) begin
        diff_r       <= d_sh_nx_s;
        borrow_out_r <= borrow_nx_s;
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor with WIDTH=8. Expected results are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   cyc;
  logic [W-1:0] last_diff;
  logic         last_borrow;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits (bounded) on falling edges until done is high
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (sif.done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(n < 30), 32'd1);
  endtask

  // One complete operation with busy-length, result and done-pulse checks
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input string tag);
    int n;
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = av;
    sif.b     = bv;
    @(negedge clk);
    sif.start = 1'b0;
    check({tag, "_diff_held"}, 32'(sif.diff), 32'(last_diff));
    check({tag, "_borrow_held"}, 32'(sif.borrow_out), 32'(last_borrow));
    n = 0;
    while (sif.busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd8);
    check({tag, "_done"}, 32'(sif.done), 32'd1);
    check({tag, "_diff"}, 32'(sif.diff), 32'(ed));
    check({tag, "_borrow"}, 32'(sif.borrow_out), 32'(eb));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(sif.done), 32'd0);
    last_diff   = ed;
    last_borrow = eb;
  endtask

  initial begin
    int t1;
    int n_done;
    total       = 0;
    passed      = 0;
    cyc         = 0;
    last_diff   = 8'd0;
    last_borrow = 1'b0;
    rst_n       = 1'b0;
    sif.start   = 1'b0;
    sif.a       = 8'd0;
    sif.b       = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    check("rst_diff", 32'(sif.diff), 32'd0);
    check("rst_borrow", 32'(sif.borrow_out), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(sif.busy), 32'd0);

    // Directed operations
    do_op(8'd100, 8'd37, 8'd63, 1'b0, "op_100_37");
    do_op(8'd5, 8'd9, 8'hFC, 1'b1, "op_5_9");
    do_op(8'd0, 8'hFF, 8'h01, 1'b1, "op_0_ff");
    do_op(8'hA5, 8'hA5, 8'h00, 1'b0, "op_a5_a5");

    // Start held high: one completion every WIDTH+2 cycles
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 8'd30;
    sif.b     = 8'd20;
    wait_done("b2b_first");
    t1 = cyc;
    check("b2b_first_diff", 32'(sif.diff), 32'd10);
    @(negedge clk);
    wait_done("b2b_second");
    check("b2b_spacing", 32'(cyc - t1), 32'd10);
    check("b2b_second_diff", 32'(sif.diff), 32'd10);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_stopped_busy", 32'(sif.busy), 32'd0);
    last_diff   = 8'd10;
    last_borrow = 1'b0;

    // Start while busy is ignored and operand changes do not leak in
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 8'd200;
    sif.b     = 8'd50;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (2) @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 8'd1;
    sif.b     = 8'd2;
    @(negedge clk);
    sif.start = 1'b0;
    wait_done("ign");
    check("ign_diff", 32'(sif.diff), 32'd150);
    check("ign_borrow", 32'(sif.borrow_out), 32'd0);
    repeat (3) @(negedge clk);
    check("ign_no_second_op", 32'(sif.busy), 32'd0);

    // Reset in the middle of SHIFT discards the partial result
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 8'd10;
    sif.b     = 8'd3;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", 32'(sif.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(sif.busy), 32'd0);
    check("mid_rst_done", 32'(sif.done), 32'd0);
    check("mid_rst_diff", 32'(sif.diff), 32'd0);
    check("mid_rst_borrow", 32'(sif.borrow_out), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (sif.done === 1'b1) n_done++;
    end
    check("mid_rst_no_done", 32'(n_done), 32'd0);
    check("mid_rst_idle", 32'(sif.busy), 32'd0);
    last_diff   = 8'd0;
    last_borrow = 1'b0;

    // Operation after reset recovery
    do_op(8'd10, 8'd3, 8'd7, 1'b0, "op_after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
